sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Shares one Gowin SDRAM controller (SDRC) command interface between NumPorts burst-cache requesters, e.g. an instruction cache and a data cache.
- Grants whole transactions round-robin; a grant is never preempted.
- Schedules periodic auto-refresh, which takes priority over new grants.
- Sits between the cache instances and the SDRC IP; caches drive their SDRC-style signals into a port of this block instead of directly into the SDRC.

Parameters:
- NumPorts, 2, number of requesters; must be ≥ 2 (arbiter index width is $clog2(NumPorts)).
- RefreshInterval, 780, cycles between refresh requests (must be ≥ 16).
- RefreshWaitCycles, 8, idle cycles after refresh ack before a new grant.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req  in  NumPorts  per-port request; held for the whole transaction
- gnt  out  NumPorts  one-hot grant, registered
- p_cmd_en  in  NumPorts  per-port command enable
- p_cmd  in  NumPorts×3  per-port SDRC command
- p_addr  in  NumPorts×21  per-port address
- p_data  in  NumPorts×32  per-port write data
- p_data_len  in  NumPorts×8  per-port burst length − 1
- p_cmd_ack  out  NumPorts  O_sdrc_cmd_ack routed to the granted port only
- p_data_out  out  32  O_sdrc_data broadcast to all ports
- p_init_done  out  1  copy of O_sdrc_init_done
- I_sdrc_cmd_en  out  1  to SDRC
- I_sdrc_cmd  out  3  to SDRC
- I_sdrc_addr  out  21  to SDRC
- I_sdrc_data  out  32  to SDRC
- I_sdrc_data_len  out  8  to SDRC
- O_sdrc_data  in  32  from SDRC
- O_sdrc_init_done  in  1  from SDRC
- O_sdrc_cmd_ack  in  1  from SDRC
- refresh_overrun  out  1  sticky: a refresh interval expired while a refresh was still pending

Behaviour:
- Reset values:
  - state = WaitInit, gnt = 0, last_gnt = NumPorts−1.
  - refresh counter = 0, refresh_pending = 0, refresh_overrun = 0.
  - all I_sdrc_* = 0.
- SDRC output mux, combinational from the gnt register:
  - if gnt[i], forward port i's cmd_en/cmd/addr/data/data_len.
  - else if in RefreshCmd, drive cmd_en = 1, cmd = 3'b001, other fields 0.
  - else drive all outputs 0.
- p_cmd_ack[i] = O_sdrc_cmd_ack & gnt[i].
- Refresh counter:
  - Counts every cycle once init_done is seen; wraps at RefreshInterval−1.
  - On wrap it sets refresh_pending.
  - Wrap while refresh_pending is already 1 sets refresh_overrun, which is cleared only by reset.
- States:
  - WaitInit: all outputs 0; go to Idle when O_sdrc_init_done = 1.
  - Idle:
    - if refresh_pending, go to RefreshCmd (refresh wins over any req in the same cycle).
    - else if any req, pick the first requesting port after last_gnt (round-robin), set gnt one-hot next cycle, update last_gnt, go to Granted.
  - Granted:
    - outputs follow the granted port.
    - when req[granted] = 0, clear gnt next cycle and go to Idle.
    - there is always at least one non-granted cycle between two grants.
    - refresh_pending accumulates but never preempts the grant.
  - RefreshCmd: assert the refresh command for exactly 1 cycle, go to RefreshAck.
  - RefreshAck: cmd_en = 0; wait for O_sdrc_cmd_ack, then load the wait counter and go to RefreshWait.
  - RefreshWait:
    - count RefreshWaitCycles cycles; then clear refresh_pending (unless a new wrap occurs that same cycle, which keeps it set) and go to Idle.
- Latency: req rising in Idle with nothing else pending → gnt high on the next clk edge (1 cycle).
- A requester that drops req in the same cycle gnt rises is still granted; the grant is released the following cycle.
- Reset mid-transaction or mid-refresh: immediate return to reset values; gnt and cmd_en go low asynchronously.
- p_init_done = O_sdrc_init_done; requesters must also wait for gnt.

Decomposition:
- Package sdram_pkg holds:
  - SDRC command constants: CmdRefresh = 3'b001, CmdActivate = 3'b011, CmdWrite = 3'b100, CmdRead = 3'b101 (shared with the cache).
  - arbiter state enum.
- One sub-module, rr_arbiter: a combinational round-robin picker taking req and last_gnt, returning a one-hot next grant.

Test Plan:
- Init:
  - hold O_sdrc_init_done = 0 with req = 2'b01 → gnt stays 0.
  - raise init_done → gnt = 2'b01 one cycle later.
- Round-robin: req = 2'b11 held, each grantee drops req after 5 cycles → grant order 01, 10, 01 with ≥ 1 idle cycle between grants.
- Passthrough: port 1 granted, p_cmd = 3'b101, addr 0x000100 → I_sdrc_cmd = 101, addr 0x000100; ack appears only on p_cmd_ack[1].
- Refresh at idle, RefreshInterval = 16:
  - at cycle 16 after init, I_sdrc_cmd = 001 with cmd_en high for 1 cycle.
  - ack after 3 cycles → no grant is given for 8 further cycles.
- Refresh vs. busy grant:
  - port 0 holds req for 40 cycles with RefreshInterval = 16 → refresh_overrun = 1.
  - exactly one refresh is issued after release, before any new grant.
- Reset asserted mid-grant → gnt = 0 and I_sdrc_cmd_en = 0 immediately; the block re-enters WaitInit.

Source files
------------

// File: rtl/sdram_pkg.sv
// SDRC command encodings shared with the burst caches, plus arbiter state codes.
package sdram_pkg;

  localparam logic [2:0] CmdRefresh  = 3'b001;
  localparam logic [2:0] CmdActivate = 3'b011;
  localparam logic [2:0] CmdWrite    = 3'b100;
  localparam logic [2:0] CmdRead     = 3'b101;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t StWaitInit    = 3'd0;
  localparam arb_state_t StIdle        = 3'd1;
  localparam arb_state_t StGranted     = 3'd2;
  localparam arb_state_t StRefreshCmd  = 3'd3;
  localparam arb_state_t StRefreshAck  = 3'd4;
  localparam arb_state_t StRefreshWait = 3'd5;

endpackage

// File: rtl/sdram_arbiter_rr.sv
// Combinational round-robin picker: first requester strictly after last_gnt_i,
// wrapping around, returned both one-hot and as an index.
module rr_arbiter #(
  parameter int NumPorts = 2
) (
  input  logic [NumPorts-1:0]         req_i,
  input  logic [$clog2(NumPorts)-1:0] last_gnt_i,
  output logic [NumPorts-1:0]         gnt_o,
  output logic [$clog2(NumPorts)-1:0] gnt_idx_o
);

  localparam int IdxW = $clog2(NumPorts);

  always_comb begin
    logic            found;
    logic [IdxW-1:0] idx;
    found     = 1'b0;
    idx       = '0;
    gnt_o     = '0;
    gnt_idx_o = last_gnt_i;
    for (int off = 1; off <= NumPorts; off++) begin
      idx = IdxW'((int'(last_gnt_i) + off) % NumPorts);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRC command port between NumPorts burst caches: whole-transaction
// round-robin grants plus periodic auto-refresh that wins over new grants.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int NumPorts          = 2,
  parameter int RefreshInterval   = 780,
  parameter int RefreshWaitCycles = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NumPorts-1:0]    req,
  output logic [NumPorts-1:0]    gnt,
  input  logic [NumPorts-1:0]    p_cmd_en,
  input  logic [NumPorts*3-1:0]  p_cmd,
  input  logic [NumPorts*21-1:0] p_addr,
  input  logic [NumPorts*32-1:0] p_data,
  input  logic [NumPorts*8-1:0]  p_data_len,
  output logic [NumPorts-1:0]    p_cmd_ack,
  output logic [31:0]            p_data_out,
  output logic                   p_init_done,
  output logic                   I_sdrc_cmd_en,
  output logic [2:0]             I_sdrc_cmd,
  output logic [20:0]            I_sdrc_addr,
  output logic [31:0]            I_sdrc_data,
  output logic [7:0]             I_sdrc_data_len,
  input  logic [31:0]            O_sdrc_data,
  input  logic                   O_sdrc_init_done,
  input  logic                   O_sdrc_cmd_ack,
  output logic                   refresh_overrun
);

  localparam int IdxW  = $clog2(NumPorts);
  localparam int RcntW = $clog2(RefreshInterval);
  localparam int WcntW = $clog2(RefreshWaitCycles + 1);
  localparam logic [RcntW-1:0] RcntMax  = RcntW'(RefreshInterval - 1);
  localparam logic [WcntW-1:0] WaitLoad = WcntW'(RefreshWaitCycles);

  arb_state_t          state_q, state_d;
  logic [NumPorts-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]     last_gnt_q, last_gnt_d;
  logic [RcntW-1:0]    rcnt_q, rcnt_d;
  logic [WcntW-1:0]    wcnt_q, wcnt_d;
  logic                init_seen_q;
  logic                pending_q, pending_d;
  logic                overrun_q, overrun_d;

  logic [NumPorts-1:0] rr_gnt;
  logic [IdxW-1:0]     rr_idx;
  logic                cnt_en, wrap;

  rr_arbiter #(.NumPorts(NumPorts)) u_rr (
    .req_i      (req),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (rr_gnt),
    .gnt_idx_o  (rr_idx)
  );

  // The refresh timer starts on the very cycle init_done is first seen.
  assign cnt_en = init_seen_q | O_sdrc_init_done;
  assign wrap   = cnt_en && (rcnt_q == RcntMax);

  always_comb begin
    rcnt_d = rcnt_q;
    if (cnt_en) rcnt_d = wrap ? '0 : rcnt_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    wcnt_d     = wcnt_q;
    pending_d  = pending_q | wrap;
    overrun_d  = overrun_q | (wrap & pending_q);
    case (state_q)
      StWaitInit: if (O_sdrc_init_done) state_d = StIdle;
      StIdle: begin
        if (pending_q) begin
          state_d = StRefreshCmd;
        end else if (|req) begin
          gnt_d      = rr_gnt;
          last_gnt_d = rr_idx;
          state_d    = StGranted;
        end
      end
      StGranted: begin
        if ((req & gnt_q) == '0) begin
          gnt_d   = '0;
          state_d = StIdle;
        end
      end
      StRefreshCmd: state_d = StRefreshAck;
      StRefreshAck: begin
        if (O_sdrc_cmd_ack) begin
          wcnt_d  = WaitLoad;
          state_d = StRefreshWait;
        end
      end
      StRefreshWait: begin
        // A wrap landing on the exit cycle is a fresh request and must survive.
        if (wcnt_q <= WcntW'(1)) begin
          pending_d = wrap;
          state_d   = StIdle;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = StWaitInit;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StWaitInit;
      gnt_q       <= '0;
      last_gnt_q  <= IdxW'(NumPorts - 1);
      rcnt_q      <= '0;
      wcnt_q      <= '0;
      init_seen_q <= 1'b0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      rcnt_q      <= rcnt_d;
      wcnt_q      <= wcnt_d;
      init_seen_q <= init_seen_q | O_sdrc_init_done;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    I_sdrc_cmd_en   = 1'b0;
    I_sdrc_cmd      = '0;
    I_sdrc_addr     = '0;
    I_sdrc_data     = '0;
    I_sdrc_data_len = '0;
    if (state_q == StRefreshCmd) begin
      I_sdrc_cmd_en = 1'b1;
      I_sdrc_cmd    = CmdRefresh;
    end
    for (int i = 0; i < NumPorts; i++) begin
      if (gnt_q[i]) begin
        I_sdrc_cmd_en   = p_cmd_en[i];
        I_sdrc_cmd      = p_cmd[i*3 +: 3];
        I_sdrc_addr     = p_addr[i*21 +: 21];
        I_sdrc_data     = p_data[i*32 +: 32];
        I_sdrc_data_len = p_data_len[i*8 +: 8];
      end
    end
  end

  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_ack
    assign p_cmd_ack[gi] = O_sdrc_cmd_ack & gnt_q[gi];
  end

  assign gnt             = gnt_q;
  assign p_data_out      = O_sdrc_data;
  assign p_init_done     = O_sdrc_init_done;
  assign refresh_overrun = overrun_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed-vector bench for sdram_arbiter with a 16-cycle refresh interval.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int NP = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP-1:0]   req;
  logic [NP-1:0]   gnt;
  logic [NP-1:0]   p_cmd_en;
  logic [NP*3-1:0] p_cmd;
  logic [NP*21-1:0] p_addr;
  logic [NP*32-1:0] p_data;
  logic [NP*8-1:0] p_data_len;
  logic [NP-1:0]   p_cmd_ack;
  logic [31:0]     p_data_out;
  logic            p_init_done;
  logic            I_sdrc_cmd_en;
  logic [2:0]      I_sdrc_cmd;
  logic [20:0]     I_sdrc_addr;
  logic [31:0]     I_sdrc_data;
  logic [7:0]      I_sdrc_data_len;
  logic [31:0]     O_sdrc_data;
  logic            O_sdrc_init_done;
  logic            O_sdrc_cmd_ack;
  logic            refresh_overrun;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .NumPorts          (NP),
    .RefreshInterval   (16),
    .RefreshWaitCycles (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .gnt              (gnt),
    .p_cmd_en         (p_cmd_en),
    .p_cmd            (p_cmd),
    .p_addr           (p_addr),
    .p_data           (p_data),
    .p_data_len       (p_data_len),
    .p_cmd_ack        (p_cmd_ack),
    .p_data_out       (p_data_out),
    .p_init_done      (p_init_done),
    .I_sdrc_cmd_en    (I_sdrc_cmd_en),
    .I_sdrc_cmd       (I_sdrc_cmd),
    .I_sdrc_addr      (I_sdrc_addr),
    .I_sdrc_data      (I_sdrc_data),
    .I_sdrc_data_len  (I_sdrc_data_len),
    .O_sdrc_data      (O_sdrc_data),
    .O_sdrc_init_done (O_sdrc_init_done),
    .O_sdrc_cmd_ack   (O_sdrc_cmd_ack),
    .refresh_overrun  (refresh_overrun)
  );

  // One cycle: returns on the falling edge, where outputs are sampled and inputs changed.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic en, input logic [2:0] cmd,
                          input logic [20:0] addr, input logic [31:0] data,
                          input logic [7:0] len);
    p_cmd_en[p]          = en;
    p_cmd[p*3 +: 3]      = cmd;
    p_addr[p*21 +: 21]   = addr;
    p_data[p*32 +: 32]   = data;
    p_data_len[p*8 +: 8] = len;
  endtask

  task automatic apply_reset();
    rst_n            = 1'b0;
    req              = '0;
    p_cmd_en         = '0;
    p_cmd            = '0;
    p_addr           = '0;
    p_data           = '0;
    p_data_len       = '0;
    O_sdrc_data      = '0;
    O_sdrc_init_done = 1'b0;
    O_sdrc_cmd_ack   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    req = 2'b11;
    set_port(0, 1'b1, CmdWrite, 21'h0ABCDE, 32'h11111111, 8'h03);
    set_port(1, 1'b1, CmdRead, 21'h1FFFFF, 32'h22222222, 8'h07);
    O_sdrc_init_done = 1'b1;
    O_sdrc_cmd_ack   = 1'b1;
    step();
    step();
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    vectors++; if (I_sdrc_cmd_en !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_en: got %b want 0", I_sdrc_cmd_en); end
    vectors++; if ({I_sdrc_cmd, I_sdrc_addr, I_sdrc_data, I_sdrc_data_len} !== 64'd0) begin
      miscompares++; $display("FAIL reset_sdrc_fields: cmd=%b addr=%h data=%h len=%h want all 0", I_sdrc_cmd, I_sdrc_addr, I_sdrc_data, I_sdrc_data_len); end
    vectors++; if (p_cmd_ack !== 2'b00) begin miscompares++; $display("FAIL reset_ack: got %b want 00", p_cmd_ack); end
    vectors++; if (refresh_overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", refresh_overrun); end
    vectors++; if (p_init_done !== 1'b1) begin miscompares++; $display("FAIL reset_init_copy: got %b want 1", p_init_done); end
    $display("test_reset: outputs held at reset values");
  endtask

  task automatic test_init();
    apply_reset();
    req = 2'b01;
    for (int c = 0; c < 5; c++) begin
      step();
      vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL init_hold c%0d: gnt=%b want 00", c, gnt); end
    end
    vectors++; if (p_init_done !== 1'b0) begin miscompares++; $display("FAIL init_copy: got %b want 0", p_init_done); end
    O_sdrc_init_done = 1'b1;
    step();
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL init_enter_idle: gnt=%b want 00", gnt); end
    step();
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL init_first_grant: gnt=%b want 01", gnt); end
    req = 2'b00;
    step();
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL init_release: gnt=%b want 00", gnt); end
    $display("test_init: first grant after init_done");
  endtask

  task automatic test_round_robin();
    logic [1:0] order [3];
    order = '{2'b01, 2'b10, 2'b01};
    apply_reset();
    req = 2'b11;
    O_sdrc_init_done = 1'b1;
    step();
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL rr_idle: gnt=%b want 00", gnt); end
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++; if (gnt !== order[k]) begin miscompares++; $display("FAIL rr_grant k%0d: gnt=%b want %b", k, gnt, order[k]); end
      for (int h = 0; h < 4; h++) begin
        step();
        vectors++; if (gnt !== order[k]) begin miscompares++; $display("FAIL rr_hold k%0d h%0d: gnt=%b want %b", k, h, gnt, order[k]); end
      end
      req = 2'b11 & ~order[k];
      step();
      vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL rr_gap k%0d: gnt=%b want 00", k, gnt); end
      req = 2'b11;
      $display("test_round_robin: grant %0d to mask %b", k, order[k]);
    end
    req = 2'b00;
  endtask

  task automatic test_passthrough();
    apply_reset();
    req = 2'b10;
    set_port(0, 1'b1, CmdWrite, 21'h01ABCD, 32'hDEADBEEF, 8'h0F);
    set_port(1, 1'b1, CmdRead, 21'h000100, 32'h12345678, 8'h07);
    O_sdrc_init_done = 1'b1;
    step();
    vectors++; if (I_sdrc_cmd_en !== 1'b0) begin miscompares++; $display("FAIL pt_ungranted_en: got %b want 0", I_sdrc_cmd_en); end
    O_sdrc_cmd_ack = 1'b1;
    #1;
    vectors++; if (p_cmd_ack !== 2'b00) begin miscompares++; $display("FAIL pt_ack_ungranted: got %b want 00", p_cmd_ack); end
    O_sdrc_cmd_ack = 1'b0;
    step();
    vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL pt_gnt: got %b want 10", gnt); end
    vectors++; if (I_sdrc_cmd_en !== 1'b1 || I_sdrc_cmd !== CmdRead) begin
      miscompares++; $display("FAIL pt_cmd: en=%b cmd=%b want 1/101", I_sdrc_cmd_en, I_sdrc_cmd); end
    vectors++; if (I_sdrc_addr !== 21'h000100) begin miscompares++; $display("FAIL pt_addr: got %h want 000100", I_sdrc_addr); end
    vectors++; if (I_sdrc_data !== 32'h12345678 || I_sdrc_data_len !== 8'h07) begin
      miscompares++; $display("FAIL pt_data: data=%h len=%h want 12345678/07", I_sdrc_data, I_sdrc_data_len); end
    O_sdrc_cmd_ack = 1'b1;
    O_sdrc_data    = 32'hCAFEF00D;
    #1;
    vectors++; if (p_cmd_ack !== 2'b10) begin miscompares++; $display("FAIL pt_ack_route: got %b want 10", p_cmd_ack); end
    vectors++; if (p_data_out !== 32'hCAFEF00D) begin miscompares++; $display("FAIL pt_data_out: got %h want cafef00d", p_data_out); end
    O_sdrc_cmd_ack = 1'b0;
    p_cmd_en[1]    = 1'b0;
    #1;
    vectors++; if (I_sdrc_cmd_en !== 1'b0) begin miscompares++; $display("FAIL pt_en_follow: got %b want 0", I_sdrc_cmd_en); end
    req = 2'b00;
    step();
    vectors++; if (gnt !== 2'b00 || I_sdrc_addr !== 21'd0) begin
      miscompares++; $display("FAIL pt_release: gnt=%b addr=%h want 00/0", gnt, I_sdrc_addr); end
    $display("test_passthrough: port 1 read forwarded");
  endtask

  task automatic test_refresh_idle();
    apply_reset();
    O_sdrc_init_done = 1'b1;
    for (int c = 0; c < 16; c++) begin
      step();
      vectors++; if (I_sdrc_cmd_en !== 1'b0) begin miscompares++; $display("FAIL rf_quiet c%0d: en=%b want 0", c, I_sdrc_cmd_en); end
    end
    step();
    vectors++; if (I_sdrc_cmd_en !== 1'b1 || I_sdrc_cmd !== CmdRefresh || I_sdrc_addr !== 21'd0) begin
      miscompares++; $display("FAIL rf_cmd: en=%b cmd=%b addr=%h want 1/001/0", I_sdrc_cmd_en, I_sdrc_cmd, I_sdrc_addr); end
    step();
    vectors++; if (I_sdrc_cmd_en !== 1'b0) begin miscompares++; $display("FAIL rf_one_cycle: en=%b want 0", I_sdrc_cmd_en); end
    step();
    req            = 2'b01;
    O_sdrc_cmd_ack = 1'b1;
    #1;
    vectors++; if (p_cmd_ack !== 2'b00) begin miscompares++; $display("FAIL rf_ack_route: got %b want 00", p_cmd_ack); end
    step();
    O_sdrc_cmd_ack = 1'b0;
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL rf_wait_entry: gnt=%b want 00", gnt); end
    for (int c = 0; c < 8; c++) begin
      step();
      vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL rf_wait c%0d: gnt=%b want 00", c, gnt); end
    end
    step();
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL rf_grant_after: gnt=%b want 01", gnt); end
    req = 2'b00;
    $display("test_refresh_idle: refresh issued and wait honoured");
  endtask

  task automatic test_refresh_busy();
    int refreshes;
    refreshes = 0;
    apply_reset();
    req = 2'b01;
    O_sdrc_init_done = 1'b1;
    step();
    for (int c = 1; c <= 40; c++) begin
      step();
      vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL busy_hold c%0d: gnt=%b want 01", c, gnt); end
      if (c == 30) begin
        vectors++; if (refresh_overrun !== 1'b0) begin miscompares++; $display("FAIL busy_overrun_early: got %b want 0", refresh_overrun); end
      end
    end
    vectors++; if (refresh_overrun !== 1'b1) begin miscompares++; $display("FAIL busy_overrun: got %b want 1", refresh_overrun); end
    req = 2'b10;
    for (int c = 41; c <= 52; c++) begin
      step();
      if (I_sdrc_cmd_en === 1'b1 && I_sdrc_cmd === CmdRefresh) refreshes++;
      vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL busy_no_grant c%0d: gnt=%b want 00", c, gnt); end
      if (c == 42) begin
        vectors++; if (I_sdrc_cmd_en !== 1'b1 || I_sdrc_cmd !== CmdRefresh) begin
          miscompares++; $display("FAIL busy_refresh_cmd: en=%b cmd=%b want 1/001", I_sdrc_cmd_en, I_sdrc_cmd); end
      end
      O_sdrc_cmd_ack = (c == 43);
    end
    step();
    vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL busy_next_grant: gnt=%b want 10", gnt); end
    vectors++; if (refreshes !== 1) begin miscompares++; $display("FAIL busy_refresh_count: got %0d want 1", refreshes); end
    vectors++; if (refresh_overrun !== 1'b1) begin miscompares++; $display("FAIL busy_overrun_sticky: got %b want 1", refresh_overrun); end
    $display("test_refresh_busy: one deferred refresh, overrun flagged");
  endtask

  // Follows test_refresh_busy while port 1 still holds its grant.
  task automatic test_reset_mid_grant();
    set_port(1, 1'b1, CmdActivate, 21'h000040, 32'h0, 8'h00);
    #1;
    vectors++; if (I_sdrc_cmd_en !== 1'b1 || I_sdrc_cmd !== CmdActivate) begin
      miscompares++; $display("FAIL mid_pre: en=%b cmd=%b want 1/011", I_sdrc_cmd_en, I_sdrc_cmd); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL mid_gnt_async: got %b want 00", gnt); end
    vectors++; if (I_sdrc_cmd_en !== 1'b0) begin miscompares++; $display("FAIL mid_en_async: got %b want 0", I_sdrc_cmd_en); end
    vectors++; if (refresh_overrun !== 1'b0) begin miscompares++; $display("FAIL mid_overrun_clr: got %b want 0", refresh_overrun); end
    step();
    O_sdrc_init_done = 1'b0;
    req   = 2'b01;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL mid_waitinit c%0d: gnt=%b want 00", c, gnt); end
    end
    O_sdrc_init_done = 1'b1;
    step();
    step();
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL mid_regrant: gnt=%b want 01", gnt); end
    req = 2'b00;
    $display("test_reset_mid_grant: asynchronous clear and re-init");
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_round_robin();
    test_passthrough();
    test_refresh_idle();
    test_refresh_busy();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
